// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO-to-stream packet reader.
package fifo_reader_pkg;

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int BUF_DEPTH = 4;
    localparam int BUF_AW    = 2;
    localparam int OCC_W     = 3;

endpackage

// File: rtl/fifo_reader_stream_buf.sv
// Four-entry valid/ready skid buffer between the FIFO read port and the output stream.
module stream_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [OCC_W-1:0]      occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [BUF_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  push, pop;

    assign out_valid_o = (occ_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    // A write into a full buffer is only accepted when a word leaves in the same cycle.
    assign push        = in_valid_i && ((occ_q != OCC_W'(BUF_DEPTH)) || pop);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign occ_o       = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + BUF_AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + BUF_AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/fifo_reader.sv
// Reads fixed-length packets out of a show-ahead-less FIFO and emits them as a framed valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [ADDR_BITS-1:0]  fifo_usedw,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_req,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop
);

    localparam logic [ADDR_BITS-1:0] PKT_LEN_W = ADDR_BITS'(PKT_LEN);
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(PKT_LEN - 1);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_BITS-1:0]   out_cnt_q, out_cnt_d;
    logic                   inflight_q;
    logic [OCC_W-1:0]       occ;
    logic                   space_ok, start_burst, last_req, accept;

    // Space check uses only registered occupancy, keeping out_ready off the request path.
    assign space_ok    = (occ + OCC_W'(inflight_q)) < OCC_W'(BUF_DEPTH);
    assign start_burst = en && (fifo_usedw >= PKT_LEN_W);
    assign last_req    = fifo_rd_req && (rd_cnt_q == LAST_IDX);
    assign accept      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:  if (start_burst) state_d = ST_BURST;
            ST_BURST: if (last_req)    state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        fifo_rd_req = (state_q == ST_BURST) && !fifo_empty && space_ok;
    end

    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        if ((state_q == ST_WAIT) && start_burst) rd_cnt_d = '0;
        else if (fifo_rd_req)                    rd_cnt_d = rd_cnt_q + ADDR_BITS'(1);
        if (accept) out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + ADDR_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= fifo_rd_req;
        end
    end

    // FIFO read data arrives one cycle after the request, so the in-flight flag is the write strobe.
    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   (fifo_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occ_o       (occ)
    );

    assign out_sop = out_valid && (out_cnt_q == '0);
    assign out_eop = out_valid && (out_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: framing, latency, backpressure, stalls, en drop and mid-burst reset.
module tb_fifo_reader;

    localparam int DW  = 16;
    localparam int AB  = 10;
    localparam int PKT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b0;
    logic [AB-1:0] fifo_usedw = '0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_req;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;

    int total = 0;
    int bad   = 0;

    int word_idx  = 0;
    int exp_word  = 0;
    int acc       = 0;
    int cyc       = 0;
    int rd_n      = 0;
    int first_rd  = -1;
    int last_rd   = -1;
    int vld_n     = 0;
    int first_vld = -1;
    int last_vld  = -1;
    bit hold_prev = 1'b0;
    logic [DW-1:0] held = '0;
    int base;

    always #5 clk = ~clk;

    fifo_reader #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .PKT_LEN    (PKT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_usedw  (fifo_usedw),
        .fifo_data   (fifo_data),
        .fifo_rd_req (fifo_rd_req),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop)
    );

    // FIFO read port: word k carries 0xA000+k and appears the cycle after its request.
    always @(posedge clk) begin
        if (fifo_rd_req) begin
            fifo_data <= 16'hA000 + 16'(word_idx);
            word_idx  <= word_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rd_n = 0; first_rd = -1; last_rd = -1;
        vld_n = 0; first_vld = -1; last_vld = -1;
    endtask

    task automatic tick();
        @(negedge clk);
        if (fifo_rd_req) begin
            rd_n++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (out_valid) begin
            vld_n++;
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
        end
        chk("sop", out_sop, out_valid && (acc % PKT == 0));
        chk("eop", out_eop, out_valid && (acc % PKT == PKT - 1));
        if (hold_prev) chk("hold", out_data, held);
        hold_prev = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
            chk("data", out_data, 32'hA000 + exp_word);
            exp_word++;
            acc++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int n, input int bound);
        for (int i = 0; i < bound && rd_n < n; i++) tick();
        chk("rd_timeout", rd_n >= n, 1);
    endtask

    task automatic run_until_acc(input int target, input int bound);
        for (int i = 0; i < bound && acc < target; i++) tick();
        chk("acc_timeout", acc, target);
    endtask

    initial begin
        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rd_req", fifo_rd_req, 0);
        chk("rst_valid",  out_valid, 0);
        chk("rst_sop",    out_sop, 0);
        chk("rst_eop",    out_eop, 0);
        chk("rst_data",   out_data, 0);
        rst = 1'b0;

        // basic packet, free-flowing output
        clear_stats();
        en = 1'b1; fifo_usedw = 10'd8;
        wait_rd(1, 5);
        en = 1'b0;
        run_until_acc(8, 30);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_rd_n",       rd_n, 8);
        chk("t1_rd_consec",  last_rd - first_rd, 7);
        chk("t1_latency",    first_vld - first_rd, 2);
        chk("t1_vld_n",      vld_n, 8);
        chk("t1_vld_consec", last_vld - first_vld, 7);

        // under-threshold fill level
        clear_stats();
        fifo_usedw = 10'd7; en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t2_no_rd", rd_n, 0);
        fifo_usedw = 10'd8;
        wait_rd(1, 5);
        en = 1'b0;
        run_until_acc(16, 30);
        chk("t2_rd_n", rd_n, 8);

        // downstream backpressure from the start
        clear_stats();
        out_ready = 1'b0; en = 1'b1;
        wait_rd(1, 5);
        en = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t3_rd_cap",   rd_n, 4);
        chk("t3_valid",    out_valid, 1);
        chk("t3_word0",    out_data, 32'hA000 + exp_word);
        chk("t3_sop_wait", out_sop, 1);
        out_ready = 1'b1;
        run_until_acc(24, 40);
        chk("t3_rd_n", rd_n, 8);

        // en dropped after the third request
        clear_stats();
        en = 1'b1;
        wait_rd(3, 10);
        en = 1'b0;
        run_until_acc(32, 30);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_rd_n", rd_n, 8);

        // FIFO goes empty for five cycles mid-burst
        clear_stats();
        en = 1'b1;
        wait_rd(3, 10);
        en = 1'b0; fifo_empty = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_stalled", rd_n, 3);
        fifo_empty = 1'b0;
        run_until_acc(40, 40);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_rd_n", rd_n, 8);

        // reset after the fourth accepted word of a packet
        clear_stats();
        base = acc;
        en = 1'b1;
        wait_rd(1, 5);
        en = 1'b0;
        run_until_acc(base + 4, 30);
        rst = 1'b1;
        #1;
        chk("t6_rd_req", fifo_rd_req, 0);
        chk("t6_valid",  out_valid, 0);
        chk("t6_sop",    out_sop, 0);
        chk("t6_eop",    out_eop, 0);
        chk("t6_data",   out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_word  = word_idx;
        acc       = 0;
        hold_prev = 1'b0;
        clear_stats();
        tick();
        chk("t6_idle", rd_n, 0);
        en = 1'b1;
        wait_rd(1, 5);
        en = 1'b0;
        for (int i = 0; i < 6 && !out_valid; i++) tick();
        chk("t6_first_sop", out_sop, 1);
        run_until_acc(8, 30);
        chk("t6_rd_n", rd_n, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
